host_mem_port: RTL and testbench



---
 rtl/host_mem_pkg.sv | 41 ++++
 rtl/host_mem_port.sv | 122 ++++++++++++
 tb/tb_host_mem_port.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/host_mem_pkg.sv
// host_mem_pkg
// Shared definitions for the host memory port.
//   state_e        : controller states (IDLE/EXEC/CAPTURE/RESP)
//   SIZE_B/H/W     : req_size encodings (log2 of access bytes)
//   size_to_mask   : low-lane byte-enable mask for an access size
//   is_misaligned  : true when addr is not a multiple of the access size
package host_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Widest mask the helper can build; callers cast down to their lane count.
  localparam int MAX_MASK_WIDTH = 64;

  // Low (1 << size) lanes set. Returns all-zero for sizes wider than the port,
  // so an oversized request can never enable a lane.
  function automatic logic [MAX_MASK_WIDTH-1:0] size_to_mask(input logic [1:0] size,
                                                            input int mask_width);
    int nbytes;
    nbytes = 1 << size;
    if (nbytes > mask_width) begin
      return '0;
    end
    return (MAX_MASK_WIDTH'(1) << nbytes) - MAX_MASK_WIDTH'(1);
  endfunction

  function automatic logic is_misaligned(input logic [63:0] addr, input logic [1:0] size);
    logic [63:0] low_bits;
    low_bits = (64'd1 << size) - 64'd1;
    return |(addr & low_bits);
  endfunction

endpackage

// File: rtl/host_mem_port.sv
// host_mem_port
// Host-side initiator for the scratchpad memory. Takes one read or write
// request at a time, checks natural alignment, drives the memory's
// byte-masked write port or registered-address read port, and returns one
// response per request.
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_write/addr/size/data   request payload (size = log2 bytes)
//   resp_valid/resp_ready      response handshake
//   resp_data/resp_error       read data (zero-extended) / reject flag
//   hw_addr/data/mask/en       memory write port
//   hr_addr/hr_data            memory read port (data one cycle after addr)
module host_mem_port
  import host_mem_pkg::*;
#(
  parameter  int NUM_BYTES  = 1 << 21,
  parameter  int DATA_WIDTH = 32,
  localparam int ADDR_WIDTH = $clog2(NUM_BYTES),
  localparam int MASK_WIDTH = DATA_WIDTH >> 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] hw_addr,
  output logic [DATA_WIDTH-1:0] hw_data,
  output logic [MASK_WIDTH-1:0] hw_mask,
  output logic                  hw_en,
  output logic [ADDR_WIDTH-1:0] hr_addr,
  input  logic [DATA_WIDTH-1:0] hr_data
);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_EXEC    = EXEC;
  localparam logic [1:0] ST_CAPTURE = CAPTURE;
  localparam logic [1:0] ST_RESP    = RESP;

  logic [1:0]            state_reg, state_next;
  logic                  write_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [MASK_WIDTH-1:0] mask_reg;
  logic                  err_reg;
  logic [DATA_WIDTH-1:0] resp_data_reg;

  logic                  accept;
  logic                  req_oversize;
  logic                  req_err;
  logic [MASK_WIDTH-1:0] req_mask;
  logic [DATA_WIDTH-1:0] capture_data;

  assign accept       = req_valid && (state_reg == ST_IDLE);
  assign req_oversize = (32'd1 << req_size) > 32'(MASK_WIDTH);
  assign req_err      = req_oversize || is_misaligned(64'(req_addr), req_size);
  assign req_mask     = MASK_WIDTH'(size_to_mask(req_size, MASK_WIDTH));

  // Memory returns lanes starting at the requested address; lanes beyond the
  // access size belong to neighbouring locations and are zeroed.
  genvar gi;
  generate
    for (gi = 0; gi < MASK_WIDTH; gi++) begin : g_lane
      assign capture_data[gi*8 +: 8] = mask_reg[gi] ? hr_data[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (accept) state_next = req_err ? ST_RESP : ST_EXEC;
      ST_EXEC:    state_next = write_reg ? ST_RESP : ST_CAPTURE;
      ST_CAPTURE: state_next = ST_RESP;
      ST_RESP:    if (resp_ready) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      write_reg     <= 1'b0;
      addr_reg      <= '0;
      data_reg      <= '0;
      mask_reg      <= '0;
      err_reg       <= 1'b0;
      resp_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        write_reg     <= req_write;
        addr_reg      <= req_addr;
        data_reg      <= req_data;
        mask_reg      <= req_mask;
        err_reg       <= req_err;
        // Writes and rejected requests answer with zero data.
        resp_data_reg <= '0;
      end else if (state_reg == ST_CAPTURE) begin
        resp_data_reg <= capture_data;
      end
    end
  end

  // hw_en is decoded from state so an asynchronous reset kills it at once.
  assign req_ready  = (state_reg == ST_IDLE);
  assign resp_valid = (state_reg == ST_RESP);
  assign resp_error = resp_valid && err_reg;
  assign resp_data  = resp_data_reg;
  assign hw_en      = (state_reg == ST_EXEC) && write_reg;
  assign hw_addr    = addr_reg;
  assign hw_data    = data_reg;
  assign hw_mask    = mask_reg;
  assign hr_addr    = addr_reg;

endmodule

// File: tb/tb_host_mem_port.sv
// tb_host_mem_port
// Drives host_mem_port against a byte-addressed memory model and checks every
// response against a reference byte array updated from the access rules.
module tb_host_mem_port;
  import host_mem_pkg::*;

  localparam int AW     = 21;
  localparam int DW     = 32;
  localparam int MW     = 4;
  localparam int MEM_SZ = 1024;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [1:0]    req_size = 2'd0;
  logic [DW-1:0] req_data = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_data;
  logic          resp_error;
  logic [AW-1:0] hw_addr;
  logic [DW-1:0] hw_data;
  logic [MW-1:0] hw_mask;
  logic          hw_en;
  logic [AW-1:0] hr_addr;
  logic [DW-1:0] hr_data = '0;

  logic [7:0] mem     [MEM_SZ];
  logic [7:0] ref_mem [MEM_SZ];

  int checks = 0;
  int errors = 0;
  int hw_en_seen = 0;
  int hw_en_exp = 0;

  host_mem_port #(.NUM_BYTES(1 << 21), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_error(resp_error),
    .hw_addr(hw_addr), .hw_data(hw_data), .hw_mask(hw_mask), .hw_en(hw_en),
    .hr_addr(hr_addr), .hr_data(hr_data)
  );

  always #5 clk = ~clk;

  // Scratchpad model: byte-masked write at hw_addr+lane, registered read.
  always @(posedge clk) begin
    int a;
    a = int'(hw_addr);
    if (hw_en) begin
      hw_en_seen++;
      for (int i = 0; i < MW; i++)
        if (hw_mask[i] && (a + i) < MEM_SZ) mem[a + i] <= hw_data[8*i +: 8];
    end
  end

  always @(posedge clk) begin
    int a;
    a = int'(hr_addr);
    for (int i = 0; i < MW; i++)
      hr_data[8*i +: 8] <= ((a + i) < MEM_SZ) ? mem[a + i] : 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; expectations come from ref_mem and the access rules.
  task automatic do_req(input logic wr, input int addr, input logic [1:0] size,
                        input logic [31:0] data, input int stall, output logic [31:0] got);
    int          nb;
    logic        err;
    logic [31:0] exp_data;
    logic [3:0]  exp_mask;
    nb       = 1 << size;
    err      = (nb > MW) || ((addr % nb) != 0);
    exp_mask = (nb > MW) ? 4'h0 : 4'((1 << nb) - 1);
    exp_data = 32'h0;
    if (!wr && !err)
      for (int i = 0; i < nb; i++) exp_data[8*i +: 8] = ref_mem[addr + i];

    check("req_ready_before", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = AW'(addr);
    req_size   = size;
    req_data   = data;
    resp_ready = (stall == 0);
    step();
    req_valid = 1'b0;
    req_addr  = AW'($urandom);
    if (err) begin
      check("err_no_write", 32'(hw_en), 32'd0);
    end else if (wr) begin
      check("wr_hw_en", 32'(hw_en), 32'd1);
      check("wr_hw_addr", 32'(hw_addr), 32'(addr));
      check("wr_hw_mask", 32'(hw_mask), 32'(exp_mask));
      check("wr_hw_data", hw_data, data);
      check("wr_no_early_resp", 32'(resp_valid), 32'd0);
      hw_en_exp++;
      for (int i = 0; i < nb; i++) ref_mem[addr + i] = data[8*i +: 8];
      step();
      check("wr_hw_en_one_cycle", 32'(hw_en), 32'd0);
    end else begin
      check("rd_no_write", 32'(hw_en), 32'd0);
      check("rd_hr_addr", 32'(hr_addr), 32'(addr));
      check("rd_no_early_resp", 32'(resp_valid), 32'd0);
      step();
      check("rd_capture_no_resp", 32'(resp_valid), 32'd0);
      step();
    end
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("resp_error", 32'(resp_error), 32'(err));
    check("resp_data", resp_data, exp_data);
    check("req_ready_busy", 32'(req_ready), 32'd0);
    got = resp_data;
    for (int k = 0; k < stall; k++) begin
      step();
      check("stall_valid", 32'(resp_valid), 32'd1);
      check("stall_data", resp_data, exp_data);
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("resp_drop", 32'(resp_valid), 32'd0);
    check("req_ready_after", 32'(req_ready), 32'd1);
    check("hw_en_count", 32'(hw_en_seen), 32'(hw_en_exp));
    $display("txn %s addr=0x%03h size=%0d data=0x%08h stall=%0d -> resp=0x%08h err=%0b",
             wr ? "WR" : "RD", addr, size, data, stall, got, err);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] rdata;
    int          addr;
    logic [1:0]  size;

    for (int i = 0; i < MEM_SZ; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end

    // Reset values
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_error", 32'(resp_error), 32'd0);
    check("rst_hw_en", 32'(hw_en), 32'd0);
    check("rst_hw_mask", 32'(hw_mask), 32'd0);
    check("rst_hw_addr", 32'(hw_addr), 32'd0);
    check("rst_hw_data", hw_data, 32'd0);
    check("rst_hr_addr", 32'(hr_addr), 32'd0);
    step();
    reset_n = 1'b1;
    step();

    // Directed plan
    do_req(1'b1, 32'h100, SIZE_W, 32'hDEADBEEF, 0, got);
    do_req(1'b1, 32'h103, SIZE_B, 32'h000000AA, 0, got);
    do_req(1'b0, 32'h100, SIZE_W, 32'h0, 0, got);
    check("plan_word_read", got, 32'hAAADBEEF);
    do_req(1'b0, 32'h102, SIZE_H, 32'h0, 0, got);
    check("plan_half_read", got, 32'h0000AAAD);
    do_req(1'b1, 32'h101, SIZE_H, 32'h12345678, 0, got);
    do_req(1'b0, 32'h102, SIZE_W, 32'h0, 0, got);
    do_req(1'b0, 32'h100, 2'd3, 32'h0, 1, got);
    do_req(1'b0, 32'h100, SIZE_W, 32'h0, 5, got);
    check("plan_stall_read", got, 32'hAAADBEEF);
    do_req(1'b0, 32'h101, SIZE_B, 32'h0, 0, got);
    check("plan_byte_read", got, 32'h000000BE);

    // Reset while a write is in EXEC
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = AW'(32'h200);
    req_size   = SIZE_W;
    req_data   = 32'hCAFEF00D;
    step();
    req_valid = 1'b0;
    check("rstmid_hw_en_before", 32'(hw_en), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rstmid_hw_en_drop", 32'(hw_en), 32'd0);
    check("rstmid_resp_valid", 32'(resp_valid), 32'd0);
    check("rstmid_hw_mask", 32'(hw_mask), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    step();
    check("rstmid_req_ready", 32'(req_ready), 32'd1);
    check("rstmid_resp_valid_after", 32'(resp_valid), 32'd0);
    for (int i = 0; i < 4; i++) check("rstmid_mem_unchanged", 32'(mem[32'h200 + i]), 32'(ref_mem[32'h200 + i]));
    check("rstmid_hw_en_count", 32'(hw_en_seen), 32'(hw_en_exp));
    do_req(1'b0, 32'h200, SIZE_W, 32'h0, 0, got);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      size = 2'($urandom_range(0, 3));
      addr = int'($urandom_range(0, MEM_SZ - 8));
      if ($urandom_range(0, 3) != 0 && size != 2'd3) addr = addr & ~((1 << size) - 1);
      rdata = $urandom;
      do_req(1'($urandom_range(0, 1)), addr, size, rdata, int'($urandom_range(0, 3)), got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
